// File: rtl/seq_detect_mealy_param.sv
// Mealy serial-pattern detector with a runtime-loadable PAT_W-bit pattern,
// overlapping/non-overlapping detection and a saturating match counter.
module seq_detect_mealy_param #(
    parameter int               PAT_W    = 4,
    parameter logic [PAT_W-1:0] PAT_INIT = 4'b1011,
    parameter int               CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din_bit,
    input  logic             overlap_en,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             dout_bit,
    output logic [CNT_W-1:0] match_cnt,
    output logic [PAT_W-1:0] pattern
);

    localparam int               FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PAT_W-1:0]  window;
    logic              accept;

    assign window = {hist_q, din_bit};
    assign accept = din_valid & ~pat_load;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q  <= PAT_INIT;
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
        end
    end

    // Next-state logic; a pattern load restarts detection and drops the bit
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (din_valid) begin
            if (dout_bit && !overlap_en) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[PAT_W-2:0];
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + 1'b1;
                end
            end
        end
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (dout_bit && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Mealy output: flags the completing bit in the same cycle
    always_comb begin
        dout_bit = 1'b0;
        if (rst && accept && fill_q == FILL_MAX && window == pat_q) begin
            dout_bit = 1'b1;
        end
    end

    assign match_cnt = cnt_q;
    assign pattern   = pat_q;

endmodule

// File: tb/tb_seq_detect_mealy_param.sv
// Scoreboard bench for seq_detect_mealy_param: stimulus queues expectations,
// a negedge monitor pops and compares them against two DUT instances (CNT_W=8 and CNT_W=2).
module tb_seq_detect_mealy_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_valid;
    logic       din_bit;
    logic       overlap_en;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       cnt_clr;

    logic       dout_bit;
    logic [7:0] match_cnt;
    logic [3:0] pattern;
    logic       dout_bit2;
    logic [1:0] match_cnt2;
    logic [3:0] pattern2;

    typedef struct {
        int          kind;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_detect_mealy_param #(.PAT_W(4), .PAT_INIT(4'b1011), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_bit(din_bit),
        .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .dout_bit(dout_bit), .match_cnt(match_cnt), .pattern(pattern)
    );

    seq_detect_mealy_param #(.PAT_W(4), .PAT_INIT(4'b1011), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_bit(din_bit),
        .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .dout_bit(dout_bit2), .match_cnt(match_cnt2), .pattern(pattern2)
    );

    // Monitor: every expectation queued during a cycle is checked at that cycle's falling edge
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] act;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                0:       act = {14'b0, dout_bit2, dout_bit};
                1:       act = {8'b0, match_cnt};
                2:       act = {8'b0, pattern2, pattern};
                default: act = {14'b0, match_cnt2};
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("[TB] FAIL %s (kind %0d): got 0x%0h, expected 0x%0h", e.name, e.kind, act, e.exp);
            end
        end
    end

    task automatic push(input int kind, input logic [15:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic b, input logic exp_dout,
                                 input logic clr, input string name);
        din_valid = valid;
        din_bit   = b;
        pat_load  = 1'b0;
        cnt_clr   = clr;
        push(0, {14'b0, exp_dout, exp_dout}, name);
        step();
        cnt_clr = 1'b0;
    endtask

    // Sends n valid bits, MSB first, with the matching per-bit dout expectations
    task automatic sendBits(input logic [15:0] bits, input logic [15:0] exp, input int n,
                            input string name);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(1'b1, bits[i], exp[i], 1'b0, name);
        end
    endtask

    task automatic checkOutput(input logic [7:0] exp_cnt, input logic [1:0] exp_cnt2,
                               input logic [3:0] exp_pat, input string name);
        din_valid = 1'b0;
        din_bit   = 1'b0;
        pat_load  = 1'b0;
        cnt_clr   = 1'b0;
        push(1, {8'b0, exp_cnt}, name);
        push(2, {8'b0, exp_pat, exp_pat}, name);
        push(3, {14'b0, exp_cnt2}, name);
        step();
    endtask

    task automatic loadPattern(input logic [3:0] p, input logic valid, input logic b,
                               input logic clr, input string name);
        pat_load  = 1'b1;
        pat_in    = p;
        din_valid = valid;
        din_bit   = b;
        cnt_clr   = clr;
        push(0, 16'h0000, name);
        step();
        pat_load  = 1'b0;
        cnt_clr   = 1'b0;
        din_valid = 1'b0;
    endtask

    // Reset asserted mid-cycle with a valid bit present; checked before the next edge
    task automatic doReset(input string name);
        rst       = 1'b0;
        din_valid = 1'b1;
        din_bit   = 1'b1;
        pat_load  = 1'b0;
        cnt_clr   = 1'b0;
        push(0, 16'h0000, name);
        push(1, 16'h0000, name);
        push(2, {8'b0, 4'b1011, 4'b1011}, name);
        push(3, 16'h0000, name);
        step();
        rst       = 1'b1;
        din_valid = 1'b0;
        step();
    endtask

    initial begin
        rst        = 1'b0;
        din_valid  = 1'b0;
        din_bit    = 1'b0;
        overlap_en = 1'b1;
        pat_load   = 1'b0;
        pat_in     = 4'b0000;
        cnt_clr    = 1'b0;
        step();

        doReset("T1 reset");

        overlap_en = 1'b1;
        sendBits(16'b1011011, 16'b0001001, 7, "T2 overlap dout");
        checkOutput(8'd2, 2'd2, 4'b1011, "T2 overlap count");

        loadPattern(4'b1011, 1'b0, 1'b0, 1'b1, "T3 load+clear");
        overlap_en = 1'b0;
        sendBits(16'b1011011, 16'b0001000, 7, "T3 nonoverlap dout");
        checkOutput(8'd1, 2'd1, 4'b1011, "T3 nonoverlap count");

        loadPattern(4'b1011, 1'b0, 1'b0, 1'b0, "T4 restart");
        overlap_en = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "T4 gap dout");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "T4 gap dout");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "T4 gap dout");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "T4 gap dout");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "T4 gap dout");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "T4 gap dout");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "T4 gap dout");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, "T4 gap match");
        checkOutput(8'd2, 2'd2, 4'b1011, "T4 gap count");
        loadPattern(4'b0110, 1'b1, 1'b0, 1'b0, "T4 load priority");
        checkOutput(8'd2, 2'd2, 4'b0110, "T4 new pattern");
        sendBits(16'b0110, 16'b0001, 4, "T4 new pattern dout");
        checkOutput(8'd3, 2'd3, 4'b0110, "T4 new pattern count");

        doReset("T5 reset");
        sendBits(16'b1011011011011011, 16'b0001001001001001, 16, "T5 run dout");
        checkOutput(8'd5, 2'd3, 4'b1011, "T5 saturation");
        sendBits(16'b01, 16'b00, 2, "T5 pre-clear dout");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, "T5 clear in match");
        checkOutput(8'd0, 2'd0, 4'b1011, "T5 clear wins");
        sendBits(16'b011, 16'b001, 3, "T5 post-clear dout");
        checkOutput(8'd1, 2'd1, 4'b1011, "T5 post-clear count");

        loadPattern(4'b0110, 1'b0, 1'b0, 1'b0, "T6 load");
        sendBits(16'b101, 16'b000, 3, "T6 partial dout");
        doReset("T6 midstream reset");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "T6 no stale match");
        sendBits(16'b1011, 16'b0001, 4, "T6 fresh match");
        checkOutput(8'd1, 2'd1, 4'b1011, "T6 count");

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) begin
            step();
        end
        if (sb_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: %0d pending, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
